dsp_post_adder: RTL and testbench
=================================

Name: dsp_post_adder

Overview:
- Post-adder/subtractor and P-output stage of the DSP48A1 slice.
- Sits directly downstream of the M pipeline register stage and consumes its 36-bit product.
- Selects X and Z operands under OPMODE control and computes Z ± (X + CIN) at 48 bits.
- Drives P, PCOUT and CARRYOUT through optional pipeline registers; P feedback supports accumulation.

Parameters:
- PREG, 1, 1 = P result register present; 0 = combinational P.
- OPMODEREG, 1, 1 = opmode input register present.
- CARRYINREG, 1, 1 = carry-in (CYI) register present.
- CARRYOUTREG, 1, 1 = carry-out register present.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" uses opmode[5]; "CARRYIN" uses the carryin port.

Ports:
- clk  in  1  clock, all registers rising-edge.
- rst  in  1  asynchronous, active-high reset of every internal register.
- ce_opmode  in  1  clock enable, opmode register.
- ce_carryin  in  1  clock enable, CYI register.
- ce_p  in  1  clock enable, P register.
- ce_carryout  in  1  clock enable, carry-out register.
- opmode  in  8  [1:0] X sel, [3:2] Z sel, [5] carry-in bit, [7] 0 = add / 1 = subtract; [4], [6] ignored.
- m  in  36  multiplier product from the M stage (unsigned).
- c  in  48  C operand.
- d  in  18  D operand, bits [11:0] used.
- a  in  18  A operand.
- b  in  18  B operand.
- pcin  in  48  cascade input from the previous slice.
- carryin  in  1  external carry-in.
- p  out  48  result.
- pcout  out  48  equals p.
- carryout  out  1  adder carry/borrow.
- carryoutf  out  1  equals carryout.

Behaviour:
- Reset: rst high asynchronously clears the opmode, CYI, P and carry-out registers to 0. With all REG parameters = 1, p, pcout, carryout and carryoutf read 0 during reset and on the first edge after release.
- rst has priority over every ce_* input. When its ce is low, a register holds its value.
- opmode_i is opmode registered when OPMODEREG = 1 (1-cycle latency), else direct. opmode_i drives all mux and arithmetic control below.
- X mux on opmode_i[1:0]:
  - 0 → 48'd0
  - 1 → {12'd0, m}
  - 2 → P feedback
  - 3 → {d[11:0], a, b}
- Z mux on opmode_i[3:2]:
  - 0 → 48'd0
  - 1 → pcin
  - 2 → P feedback
  - 3 → c
- Carry-in:
  - cin_src = opmode_i[5] when CARRYINSEL = "OPMODE5", carryin when "CARRYIN".
  - cin = CYI register output when CARRYINREG = 1, else cin_src.
  - Any other CARRYINSEL string: cin = 0 and a simulation $error is raised at elaboration.
- Arithmetic, 49-bit unsigned:
  - add: r = {1'b0,Z} + {1'b0,X} + cin
  - subtract: r = {1'b0,Z} − ({1'b0,X} + cin)
  - result = r[47:0], carryout source = r[48]. On subtract this is the borrow, e.g. 0 − 1 → r[48] = 1.
  - Wrap-around modulo 2^48; no saturation.
- P feedback is the P register output. With PREG = 0, selecting P on X or Z yields 0, and a simulation warning is emitted once.
- Latency from m/c/pcin/a/b/d to p:
  - PREG = 1: 1 cycle
  - PREG = 0: 0 cycles
  - opmode changes add OPMODEREG cycles
  - carryin adds CARRYINREG cycles
- carryout is registered when CARRYOUTREG = 1 with ce_carryout, updating on the same edge as P when both enables are high.
- Accumulate (X = m, Z = P, ce_p held high) adds m every cycle. With ce_p low, P and its feedback freeze.
- Simultaneous X = P and Z = P is legal and computes 2·P or 0 (subtract), including cin.
- rst asserted mid-accumulation clears P immediately, without waiting for clk. Accumulation resumes from 0 on the first edge with rst low.

Decomposition:
- Shared package dsp_pkg:
  - widths P_W = 48, M_W = 36, AB_W = 18.
  - opmode field bit positions.
  - X/Z select encodings (X_ZERO, X_M, X_P, X_DAB, Z_ZERO, Z_PCIN, Z_P, Z_C).
- All optional registers are instances of the existing ff_and_mux with SYN_OR_ASN = "ASYNC" and ENable_ff bound to the matching REG parameter:
  - opmode: WIDTH 8
  - CYI: WIDTH 1
  - P: WIDTH 48
  - carry-out: WIDTH 1
- No other sub-module; the mux and adder logic is inline.

Test Plan:
- Reset: drive nonzero inputs with opmode = 8'h0D, pulse rst between edges → p = 0 and carryout = 0 immediately, with no clk edge required.
- Multiply pass: opmode = 8'h01 (X = m, Z = 0, add), m = 36'h0_0000_1234 → p = 48'h1234 two edges after opmode is applied (OPMODEREG + PREG), carryout = 0.
- Accumulate: opmode = 8'h09 (X = m, Z = P), m = 5 for 4 cycles from p = 0 → p = 5, 10, 15, 20. Drop ce_p for 2 cycles → p holds 20.
- Subtract with carry: CARRYINSEL = "OPMODE5", opmode = 8'hAD (X = m, Z = C, subtract, cin = 1), c = 100, m = 10 → p = 89, carryout = 0. Then c = 0, m = 0 → p = 48'hFFFF_FFFF_FFFF, carryout = 1.
- Overflow/cascade: opmode = 8'h07 (X = D:A:B, Z = pcin, add), {d[11:0], a, b} = 48'hFFFF_FFFF_FFFF, pcin = 1 → p = 0, carryout = 1, pcout = p.
- Bypass: all REG params = 0, opmode = 8'h0D, c = 7, m = 3 → p = 10 in the same cycle (combinational), no clk edge required.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared widths, opmode field positions and X/Z select encodings for the DSP slice.
package dsp_pkg;

  localparam int P_W  = 48;
  localparam int M_W  = 36;
  localparam int AB_W = 18;

  // Opmode field bit positions
  localparam int OP_X_LSB   = 0;
  localparam int OP_Z_LSB   = 2;
  localparam int OP_CIN_BIT = 5;
  localparam int OP_SUB_BIT = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/ff_and_mux.sv
// Optional pipeline register: a clock-enabled flop when ENable_ff = 1, a wire otherwise.
module ff_and_mux #(
  parameter int WIDTH      = 1,
  parameter     SYN_OR_ASN = "ASYNC",
  parameter int ENable_ff  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (ENable_ff == 0) begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ rst ^ ce;
      assign q = d;
    end else if (SYN_OR_ASN == "ASYNC") begin : g_async
      logic [WIDTH-1:0] r_q;
      // Register with asynchronous clear; rst overrides ce
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_q <= '0;
        else if (ce) r_q <= d;
      end
      assign q = r_q;
    end else begin : g_sync
      logic [WIDTH-1:0] r_q;
      // Register with synchronous clear; rst overrides ce
      always_ff @(posedge clk) begin
        if (rst)     r_q <= '0;
        else if (ce) r_q <= d;
      end
      assign q = r_q;
    end
  endgenerate

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder/subtractor and P output stage: Z +/- (X + CIN) at 48 bits with optional pipeline registers.
module dsp_post_adder
  import dsp_pkg::*;
#(
  parameter int PREG        = 1,
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter int CARRYOUTREG = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce_opmode,
  input  logic            ce_carryin,
  input  logic            ce_p,
  input  logic            ce_carryout,
  input  logic [7:0]      opmode,
  input  logic [M_W-1:0]  m,
  input  logic [P_W-1:0]  c,
  input  logic [AB_W-1:0] d,
  input  logic [AB_W-1:0] a,
  input  logic [AB_W-1:0] b,
  input  logic [P_W-1:0]  pcin,
  input  logic            carryin,
  output logic [P_W-1:0]  p,
  output logic [P_W-1:0]  pcout,
  output logic            carryout,
  output logic            carryoutf
);

  logic [7:0]     w_opmode_i;
  logic           w_cin_src;
  logic           w_cyi_q;
  logic           w_cin;
  logic [P_W-1:0] w_p_q;
  logic [P_W-1:0] w_p_fb;
  logic [P_W-1:0] w_x;
  logic [P_W-1:0] w_z;
  logic [P_W:0]   w_sum;
  logic           w_co_q;
  logic           w_unused;

  // Opmode register
  ff_and_mux #(.WIDTH(8), .SYN_OR_ASN("ASYNC"), .ENable_ff(OPMODEREG)) u_opmode_reg (
    .clk(clk), .rst(rst), .ce(ce_opmode), .d(opmode), .q(w_opmode_i)
  );

  // Carry-in source selection; an unknown selector string is a configuration error
  generate
    if (CARRYINSEL == "OPMODE5") begin : g_cin_op5
      assign w_cin_src = w_opmode_i[OP_CIN_BIT];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
      assign w_cin_src = carryin;
    end else begin : g_cin_bad
      $error("dsp_post_adder: unsupported CARRYINSEL value");
      assign w_cin_src = 1'b0;
    end
  endgenerate

  // CYI register
  ff_and_mux #(.WIDTH(1), .SYN_OR_ASN("ASYNC"), .ENable_ff(CARRYINREG)) u_cyi_reg (
    .clk(clk), .rst(rst), .ce(ce_carryin), .d(w_cin_src), .q(w_cyi_q)
  );

  assign w_cin = w_cyi_q;

  // Without a P register there is nothing to feed back; avoid a combinational loop
  assign w_p_fb = (PREG != 0) ? w_p_q : '0;

  // X and Z operand muxes
  always_comb begin
    w_x = '0;
    w_z = '0;
    case (x_sel_e'(w_opmode_i[OP_X_LSB +: 2]))
      X_ZERO:  w_x = '0;
      X_M:     w_x = {{(P_W-M_W){1'b0}}, m};
      X_P:     w_x = w_p_fb;
      X_DAB:   w_x = {d[11:0], a, b};
      default: w_x = '0;
    endcase
    case (z_sel_e'(w_opmode_i[OP_Z_LSB +: 2]))
      Z_ZERO:  w_z = '0;
      Z_PCIN:  w_z = pcin;
      Z_P:     w_z = w_p_fb;
      Z_C:     w_z = c;
      default: w_z = '0;
    endcase
  end

  // 49-bit add/subtract; bit 48 is carry on add, borrow on subtract
  always_comb begin
    w_sum = '0;
    if (w_opmode_i[OP_SUB_BIT])
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + {{P_W{1'b0}}, w_cin});
    else
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {{P_W{1'b0}}, w_cin};
  end

  // P result register
  ff_and_mux #(.WIDTH(P_W), .SYN_OR_ASN("ASYNC"), .ENable_ff(PREG)) u_p_reg (
    .clk(clk), .rst(rst), .ce(ce_p), .d(w_sum[P_W-1:0]), .q(w_p_q)
  );

  // Carry-out register
  ff_and_mux #(.WIDTH(1), .SYN_OR_ASN("ASYNC"), .ENable_ff(CARRYOUTREG)) u_co_reg (
    .clk(clk), .rst(rst), .ce(ce_carryout), .d(w_sum[P_W]), .q(w_co_q)
  );

  assign p         = w_p_q;
  assign pcout     = w_p_q;
  assign carryout  = w_co_q;
  assign carryoutf = w_co_q;

  // Opmode bits 4 and 6, the upper D bits and (in OPMODE5 mode) carryin are don't-cares
  assign w_unused = ^{w_opmode_i[4], w_opmode_i[6], d[AB_W-1:12], carryin};

endmodule

// File: tb/tb_dsp_post_adder.sv
// Randomised and directed checks of dsp_post_adder against a cycle-level arithmetic model.
module tb_dsp_post_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_opmode = 1'b1, ce_carryin = 1'b1, ce_p = 1'b1, ce_carryout = 1'b1;
  logic [7:0]  opmode = '0;
  logic [35:0] m = '0;
  logic [47:0] c = '0;
  logic [17:0] d = '0, a = '0, b = '0;
  logic [47:0] pcin = '0;
  logic        carryin = 1'b0;

  logic [47:0] p, pcout, p_b, pcout_b;
  logic        carryout, carryoutf, co_b, cof_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: registered opmode, carry-in flop, P and carry-out
  logic [7:0]  mdl_op;
  logic        mdl_cyi;
  logic [47:0] mdl_p;
  logic        mdl_co;

  always #5 clk = ~clk;

  dsp_post_adder u_dut (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .ce_carryout(ce_carryout), .opmode(opmode), .m(m), .c(c), .d(d), .a(a), .b(b),
    .pcin(pcin), .carryin(carryin), .p(p), .pcout(pcout), .carryout(carryout),
    .carryoutf(carryoutf)
  );

  dsp_post_adder #(.PREG(0), .OPMODEREG(0), .CARRYINREG(0), .CARRYOUTREG(0)) u_byp (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .ce_carryout(ce_carryout), .opmode(opmode), .m(m), .c(c), .d(d), .a(a), .b(b),
    .pcin(pcin), .carryin(carryin), .p(p_b), .pcout(pcout_b), .carryout(co_b),
    .carryoutf(cof_b)
  );

  // Z +/- (X + cin) in 49-bit arithmetic from the current operand inputs
  function automatic logic [48:0] calc(input logic [7:0] op, input logic [47:0] pfb, input logic cin);
    logic [48:0] x, z;
    case (op[1:0])
      2'd0: x = 49'd0;
      2'd1: x = {13'd0, m};
      2'd2: x = {1'b0, pfb};
      default: x = {1'b0, d[11:0], a, b};
    endcase
    case (op[3:2])
      2'd0: z = 49'd0;
      2'd1: z = {1'b0, pcin};
      2'd2: z = {1'b0, pfb};
      default: z = {1'b0, c};
    endcase
    if (op[7]) return z - x - 49'(cin);
    else       return z + x + 49'(cin);
  endfunction

  task automatic model_clear();
    mdl_op = '0; mdl_cyi = 1'b0; mdl_p = '0; mdl_co = 1'b0;
  endtask

  // One rising edge for DUT and model, then return on the following falling edge
  task automatic step();
    logic [48:0] r;
    @(posedge clk);
    r = calc(mdl_op, mdl_p, mdl_cyi);
    if (ce_p)        mdl_p   = r[47:0];
    if (ce_carryout) mdl_co  = r[48];
    if (ce_carryin)  mdl_cyi = mdl_op[5];
    if (ce_opmode)   mdl_op  = opmode;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    n_vec++;
    if (p !== 48'd0 || carryout !== 1'b0) begin
      n_err++; $display("FAIL reset_hold p=%h co=%b expected p=0 co=0", p, carryout);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (p !== 48'd0 || carryout !== 1'b0) begin
      n_err++; $display("FAIL reset_first_edge p=%h co=%b expected p=0 co=0", p, carryout);
    end
    // Build a nonzero P, then clear it asynchronously between edges
    opmode = 8'h0D; c = 48'h0000_0000_1111; m = 36'h0_0000_2222;
    d = 18'h3ABCD; a = 18'h12345; b = 18'h2F00F; pcin = 48'h1;
    step(); step();
    n_vec++;
    if (p !== 48'h3333) begin
      n_err++; $display("FAIL reset_preload p=%h expected %h", p, 48'h3333);
    end
    #2 rst = 1'b1;
    #1;
    model_clear();
    n_vec++;
    if (p !== 48'd0 || carryout !== 1'b0 || pcout !== 48'd0) begin
      n_err++; $display("FAIL reset_async p=%h co=%b expected p=0 co=0", p, carryout);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    $display("reset: async clear checked");
  endtask

  task automatic test_multiply_pass();
    opmode = 8'h01; m = 36'h0_0000_1234;
    step(); step();
    n_vec++;
    if (p !== 48'h1234 || carryout !== 1'b0) begin
      n_err++; $display("FAIL mult_pass p=%h co=%b expected p=1234 co=0", p, carryout);
    end
    $display("mult_pass: p=%h", p);
  endtask

  task automatic test_accumulate();
    logic [47:0] exp_p;
    rst = 1'b1; #1 rst = 1'b0; model_clear();
    opmode = 8'h09; m = 36'd5;
    step();  // opmode lands in its register; P still 0
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_p = 48'(5 * i);
      n_vec++;
      if (p !== exp_p || p !== mdl_p) begin
        n_err++; $display("FAIL accumulate[%0d] p=%0d expected %0d", i, p, exp_p);
      end
      $display("accumulate: cycle %0d p=%0d", i, p);
    end
    ce_p = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (p !== 48'd20) begin
        n_err++; $display("FAIL accumulate_hold[%0d] p=%0d expected 20", i, p);
      end
      $display("accumulate_hold: p=%0d", p);
    end
    ce_p = 1'b1;
  endtask

  task automatic test_subtract();
    opmode = 8'hAD; c = 48'd100; m = 36'd10;
    step(); step(); step();  // opmode register, then CYI picks up bit 5, then P
    n_vec++;
    if (p !== 48'd89 || carryout !== 1'b0) begin
      n_err++; $display("FAIL subtract p=%0d co=%b expected p=89 co=0", p, carryout);
    end
    $display("subtract: p=%0d co=%b", p, carryout);
    c = 48'd0; m = 36'd0;
    step();
    n_vec++;
    if (p !== 48'hFFFF_FFFF_FFFF || carryout !== 1'b1 || carryoutf !== 1'b1) begin
      n_err++; $display("FAIL subtract_borrow p=%h co=%b expected p=ffffffffffff co=1", p, carryout);
    end
    $display("subtract_borrow: p=%h co=%b", p, carryout);
  endtask

  task automatic test_overflow_cascade();
    opmode = 8'h07; d = 18'h00FFF; a = 18'h3FFFF; b = 18'h3FFFF; pcin = 48'd1;
    step(); step(); step();  // allow the CYI flop to drop back to 0
    n_vec++;
    if (p !== 48'd0 || carryout !== 1'b1 || pcout !== p || carryoutf !== carryout) begin
      n_err++; $display("FAIL overflow p=%h co=%b pcout=%h expected p=0 co=1 pcout=0", p, carryout, pcout);
    end
    $display("overflow: p=%h co=%b pcout=%h", p, carryout, pcout);
  endtask

  task automatic test_bypass();
    opmode = 8'h0D; c = 48'd7; m = 36'd3;
    #1;
    n_vec++;
    if (p_b !== 48'd10 || co_b !== 1'b0 || pcout_b !== 48'd10) begin
      n_err++; $display("FAIL bypass p=%0d co=%b expected p=10 co=0", p_b, co_b);
    end
    $display("bypass: p=%0d", p_b);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [48:0] r;
    rst = 1'b1; #1 rst = 1'b0; model_clear();
    for (int i = 0; i < 300; i++) begin
      opmode = 8'($urandom);
      m = {4'($urandom), 32'($urandom)};
      c = {16'($urandom), 32'($urandom)};
      pcin = {16'($urandom), 32'($urandom)};
      d = 18'($urandom); a = 18'($urandom); b = 18'($urandom);
      carryin = 1'($urandom);
      ce_opmode = ($urandom_range(0, 7) != 0);
      ce_carryin = ($urandom_range(0, 7) != 0);
      ce_p = ($urandom_range(0, 7) != 0);
      ce_carryout = ($urandom_range(0, 7) != 0);
      #1;
      r = calc(opmode, 48'd0, opmode[5]);
      n_vec++;
      if (p_b !== r[47:0] || co_b !== r[48] || cof_b !== r[48]) begin
        n_err++; $display("FAIL rand_bypass[%0d] op=%h p=%h co=%b expected p=%h co=%b", i, opmode, p_b, co_b, r[47:0], r[48]);
      end
      step();
      n_vec++;
      if (p !== mdl_p || pcout !== mdl_p || carryout !== mdl_co || carryoutf !== mdl_co) begin
        n_err++; $display("FAIL rand_pipe[%0d] p=%h co=%b expected p=%h co=%b", i, p, carryout, mdl_p, mdl_co);
      end
      $display("random[%0d]: op=%h ce=%b%b%b%b p=%h co=%b", i, opmode, ce_opmode, ce_carryin, ce_p, ce_carryout, p, carryout);
    end
    ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1; ce_carryout = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_multiply_pass();
    test_accumulate();
    test_subtract();
    test_overflow_cascade();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
